div_seq: RTL
============

// Module: div_seq
// PURPOSE
//   Iterative radix-2 restoring divider sequencer serving the EX stage for DIV/DIVU.
//   EX raises start_i and holds the operands; this block runs the shift-subtract loop,
//   drives stallreq_o to freeze the pipeline, and returns {remainder, quotient} for the HI/LO write.
//   The pipeline flush (annul_i) aborts an operation in flight.
// PARAMETERS
//   WIDTH    32   operand width; quotient and remainder are each WIDTH bits (only 32 is verified)
// PORTS
//   clk           in   1        system clock, rising edge
//   rst           in   1        asynchronous, active-low reset
//   start_i       in   1        divide request from EX; held high until ready_o is seen
//   annul_i       in   1        flush; aborts the current or pending operation
//   signed_div_i  in   1        1 = DIV (two's complement), 0 = DIVU
//   opdata1_i     in   WIDTH    dividend; sampled in FREE only
//   opdata2_i     in   WIDTH    divisor; sampled in FREE only
//   result_o      out  2*WIDTH  {remainder, quotient}; registered
//   ready_o       out  1        result valid; registered
//   divzero_o     out  1        last result came from a zero divisor; registered
//   stallreq_o    out  1        combinational: start_i & ~ready_o & ~annul_i
// BEHAVIOUR
//   Reset (async, rst=0): state=FREE, cnt=0, result_o=0, ready_o=0, divzero_o=0, dividend/divisor regs=0.
//   States: FREE, BYZERO, ON, END.
//   FREE:   start_i & ~annul_i & opdata2_i==0 -> BYZERO.
//           start_i & ~annul_i & opdata2_i!=0 -> ON. Latch |op1| and |op2|: magnitudes when signed_div_i
//           is set, raw values otherwise. Latch the sign flags. Set dividend={WIDTH'0, |op1|, 1'b0}, cnt=0.
//   BYZERO: -> END. result_o=0, divzero_o=1.
//   ON:     while cnt!=WIDTH, one iteration per cycle, then cnt++:
//             trial = dividend[2W:W] - {1'b0, divisor}.
//             If trial[W]=1 (negative): dividend <<= 1.
//             Else: dividend = {trial[W-1:0], dividend[W-1:0], 1'b1}.
//           At cnt==WIDTH: quot = dividend[W-1:0], rem = dividend[2W:W+1].
//             If signed and the signs differ, quot is negated. If signed and the dividend is negative, rem is negated.
//             Write result_o, divzero_o=0, -> END.
//   END:    ready_o=1 and result_o held stable. start_i==0 -> FREE with ready_o=0. start_i==1 -> stay in END.
//   annul_i=1 in any state: next state FREE, ready_o=0, cnt=0. result_o keeps its old value (don't-care).
//   Latency, nonzero divisor: ready_o is high WIDTH+2 cycles after the first cycle start_i is sampled (34 @ W=32).
//   Latency, zero divisor: ready_o is high 2 cycles after start_i is sampled.
//   stallreq_o is high every cycle from start_i rise until the cycle ready_o is high, inclusive of none after.
//   Wrap: signed 0x80000000 / 0xFFFFFFFF gives quot=0x80000000, rem=0. No exception is raised.
//   Operands are not re-sampled after FREE; EX operand changes mid-operation are ignored.
//   The registered result_o is never updated by any state other than BYZERO and ON-completion.
// CONFIGURATION
//   DIV_EARLY_OUT_EN defined:
//     In FREE with nonzero divisor and |op1| < |op2| (unsigned magnitude compare), go directly to END
//     with quot=0, rem=opdata1_i unchanged. ready_o is high 2 cycles after start.
//   DIV_EARLY_OUT_EN undefined: every nonzero-divisor operation takes the full WIDTH+2 cycles.
// STRUCTURE
//   defines.v holds:
//     state codes `DivFree/`DivByZero/`DivOn/`DivEnd (2 bits)
//     `DivResultReady/`DivResultNotReady
//     `DivStart/`DivStop
//     `DoubleRegBus reuse
//   Sub-module div_step (combinational): inputs dividend[2W:0] and divisor; outputs next dividend.
//     Isolates the trial subtract so it can be unit-tested.
//   FSM, counter and sign fix-up stay in div_seq.
// TESTING
//   1 DIVU 100/7: quot=14, rem=2. ready_o at cycle 34. stallreq_o high on cycles 0..33.
//   2 DIV -7/2 (0xFFFFFFF9/2): quot=0xFFFFFFFD, rem=0xFFFFFFFF.
//   3 DIV 0x80000000/0xFFFFFFFF: quot=0x80000000, rem=0.
//   4 DIVU 5/0: result_o=0, divzero_o=1, ready_o at cycle 2.
//   5 annul_i at cycle 10 of 50/3: FREE at cycle 11, ready_o stays 0.
//     Then a new start 20/4 gives quot=5, rem=0 after the full latency.
//   6 rst low at cycle 15 of a divide: all outputs 0 immediately, without waiting for a clock.
//     With DIV_EARLY_OUT_EN: 3/10 gives ready at cycle 2, quot=0, rem=3. Without it, ready at cycle 34.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared types and constants for the sequential divider.
package div_seq_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [1:0] {
    StFree   = 2'd0,
    StByZero = 2'd1,
    StOn     = 2'd2,
    StEnd    = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division iteration: trial subtract of the divisor from the upper partial remainder.
module div_seq_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [2*WIDTH:0] dividend_next
);

  logic [WIDTH:0] trial;

  always_comb begin
    trial = dividend[2*WIDTH:WIDTH] - {1'b0, divisor};
    if (trial[WIDTH]) begin
      dividend_next = {dividend[2*WIDTH-1:0], 1'b0};
    end else begin
      dividend_next = {trial[WIDTH-1:0], dividend[WIDTH-1:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU with pipeline stall and flush.
// Optional DIV_EARLY_OUT_EN: skip the loop when |dividend| < |divisor|.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               divzero_o,
  output logic               stallreq_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  div_state_e         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH:0]   dividend_q, dividend_d, dividend_step;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;
  logic               divzero_q, divzero_d;

  logic [WIDTH-1:0]   op1_mag, op2_mag;
  logic [WIDTH-1:0]   quot_raw, rem_raw, quot_fix, rem_fix;

  div_seq_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .dividend      (dividend_q),
    .divisor       (divisor_q),
    .dividend_next (dividend_step)
  );

  always_comb begin
    op1_mag  = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    op2_mag  = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
    quot_raw = dividend_q[WIDTH-1:0];
    rem_raw  = dividend_q[2*WIDTH:WIDTH+1];
    quot_fix = neg_quot_q ? (~quot_raw + 1'b1) : quot_raw;
    rem_fix  = neg_rem_q ? (~rem_raw + 1'b1) : rem_raw;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;
    divzero_d  = divzero_q;

    if (annul_i) begin
      state_d = StFree;
      ready_d = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StFree: begin
          if (start_i) begin
            if (opdata2_i == '0) begin
              state_d = StByZero;
            end else begin
              state_d    = StOn;
              cnt_d      = '0;
              divisor_d  = op2_mag;
              neg_quot_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
              neg_rem_d  = signed_div_i && opdata1_i[WIDTH-1];
              dividend_d = {{WIDTH{1'b0}}, op1_mag, 1'b0};
`ifdef DIV_EARLY_OUT_EN
              // Preload a finished loop: quot=0, rem=|op1|; the sign fix-up restores opdata1_i.
              if (op1_mag < op2_mag) begin
                dividend_d = {op1_mag, {(WIDTH + 1){1'b0}}};
                cnt_d      = CntW'(WIDTH);
              end
`endif
            end
          end
        end
        StByZero: begin
          result_d  = '0;
          divzero_d = 1'b1;
          ready_d   = 1'b1;
          state_d   = StEnd;
        end
        StOn: begin
          if (cnt_q != CntW'(WIDTH)) begin
            dividend_d = dividend_step;
            cnt_d      = cnt_q + 1'b1;
          end else begin
            result_d  = {rem_fix, quot_fix};
            divzero_d = 1'b0;
            ready_d   = 1'b1;
            cnt_d     = '0;
            state_d   = StEnd;
          end
        end
        StEnd: begin
          if (!start_i) begin
            state_d = StFree;
            ready_d = 1'b0;
          end
        end
        default: state_d = StFree;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StFree;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
      divzero_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
      divzero_q  <= divzero_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign divzero_o  = divzero_q;
  assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule
